// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C register write/read master on a rib slave port.
// Drives open-drain SCL/SDA enables and pulses an interrupt when a command ends.
module i2c_master #(
  parameter logic [15:0] DIV_RESET = 16'd125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        int_sig_o
);

  typedef enum logic [3:0] {
    IDLE, START, DEVW, REG, DATAW, RESTART, DEVR, DATAR, STOP
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [1:0]  quarter;
  logic [1:0]  nxt_quarter;
  logic [3:0]  bit_idx;
  logic [3:0]  nxt_bit;
  logic [15:0] div_reg;
  logic [15:0] div_eff;
  logic [15:0] cnt;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic [7:0]  data_reg;
  logic [7:0]  rx_shift;
  logic [7:0]  nxt_byte;
  logic [1:0]  nxt_drive;
  logic        rw_reg;
  logic        nack_reg;
  logic        busy;
  logic        ack_bit;
  logic        tick;
  logic        in_byte;
  logic        set_nack;
  logic        load_data;
  logic        done;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

  // Line enables {scl_oe, sda_oe} for a given state, quarter and bit slot.
  // Slot 8 of every byte field is the ACK slot, where SDA is always released.
  function automatic logic [1:0] bus_drive(input state_t s, input logic [1:0] q,
                                           input logic [3:0] b, input logic [7:0] tx);
    logic [1:0] d;
    d = 2'b00;
    case (s)
      START:   d = q[1] ? 2'b01 : 2'b00;
      RESTART: begin
        case (q)
          2'd0:    d = 2'b10;
          2'd1:    d = 2'b00;
          default: d = 2'b01;
        endcase
      end
      STOP: begin
        case (q)
          2'd0:    d = 2'b11;
          2'd3:    d = 2'b00;
          default: d = 2'b01;
        endcase
      end
      DEVW, REG, DATAW, DEVR: d = {~q[1], b[3] ? 1'b0 : ~tx[3'd7 - b[2:0]]};
      DATAR:   d = {~q[1], 1'b0};
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Quarter tick and the position (state, quarter, bit) reached at that tick,
  // together with the line levels to present there.
  always_comb begin
    tick        = busy && (cnt == div_eff - 16'd1);
    in_byte     = (state == DEVW) || (state == REG) || (state == DATAW) ||
                  (state == DEVR) || (state == DATAR);
    nxt_state   = state;
    nxt_quarter = quarter + 2'd1;
    nxt_bit     = bit_idx;
    set_nack    = 1'b0;
    load_data   = 1'b0;
    done        = 1'b0;
    if (quarter == 2'd3) begin
      case (state)
        START: begin
          nxt_state = DEVW;
          nxt_bit   = 4'd0;
        end
        RESTART: begin
          nxt_state = DEVR;
          nxt_bit   = 4'd0;
        end
        DEVW, REG, DATAW, DEVR, DATAR: begin
          if (!bit_idx[3]) begin
            nxt_bit = bit_idx + 4'd1;
          end else begin
            nxt_bit = 4'd0;
            if (state != DATAR && ack_bit) begin
              nxt_state = STOP;
              set_nack  = 1'b1;
            end else begin
              case (state)
                DEVW:    nxt_state = REG;
                REG:     nxt_state = rw_reg ? RESTART : DATAW;
                DEVR:    nxt_state = DATAR;
                DATAR: begin
                  nxt_state = STOP;
                  load_data = 1'b1;
                end
                default: nxt_state = STOP;
              endcase
            end
          end
        end
        STOP: begin
          nxt_state = IDLE;
          done      = 1'b1;
        end
        default: nxt_state = IDLE;
      endcase
    end
    case (nxt_state)
      DEVW:    nxt_byte = {dev_addr, 1'b0};
      REG:     nxt_byte = reg_addr;
      DATAW:   nxt_byte = data_reg;
      DEVR:    nxt_byte = {dev_addr, 1'b1};
      default: nxt_byte = 8'h00;
    endcase
    nxt_drive = bus_drive(nxt_state, nxt_quarter, nxt_bit, nxt_byte);
  end

  // Register file, command launch and the bit-level bus sequencer.
  // DIV is copied into div_eff at GO so a running transfer keeps its rate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      quarter   <= 2'd0;
      bit_idx   <= 4'd0;
      cnt       <= 16'd0;
      div_eff   <= 16'd0;
      div_reg   <= DIV_RESET;
      dev_addr  <= 7'd0;
      reg_addr  <= 8'd0;
      data_reg  <= 8'd0;
      rx_shift  <= 8'd0;
      rw_reg    <= 1'b0;
      nack_reg  <= 1'b0;
      busy      <= 1'b0;
      ack_bit   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      int_sig_o <= 1'b0;
    end else begin
      int_sig_o <= 1'b0;
      if (!busy) begin
        if (we_i) begin
          case (addr_i[7:0])
            8'h00: begin
              if (data_i[0]) begin
                rw_reg   <= data_i[1];
                nack_reg <= 1'b0;
                busy     <= 1'b1;
                state    <= START;
                quarter  <= 2'd0;
                bit_idx  <= 4'd0;
                cnt      <= 16'd0;
                div_eff  <= (div_reg < 16'd2) ? 16'd2 : div_reg;
              end
            end
            8'h04: div_reg <= data_i[15:0];
            8'h08: begin
              dev_addr <= data_i[6:0];
              reg_addr <= data_i[15:8];
            end
            8'h0C: data_reg <= data_i[7:0];
            default: ;
          endcase
        end
      end else if (tick) begin
        cnt              <= 16'd0;
        state            <= nxt_state;
        quarter          <= nxt_quarter;
        bit_idx          <= nxt_bit;
        {scl_oe, sda_oe} <= nxt_drive;
        if (in_byte && quarter == 2'd2) begin
          if (bit_idx[3]) ack_bit <= sda_i;
          else            rx_shift <= {rx_shift[6:0], sda_i};
        end
        if (set_nack)  nack_reg <= 1'b1;
        if (load_data) data_reg <= rx_shift;
        if (done) begin
          busy      <= 1'b0;
          int_sig_o <= 1'b1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Combinational register read-back; unmapped addresses and unused bits read 0.
  always_comb begin
    data_o = 32'd0;
    case (addr_i[7:0])
      8'h00:   data_o[3:0]  = {nack_reg, busy, rw_reg, 1'b0};
      8'h04:   data_o[15:0] = div_reg;
      8'h08:   data_o[15:0] = {reg_addr, 1'b0, dev_addr};
      8'h0C:   data_o[7:0]  = data_reg;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural I2C slave
// that logs START/STOP events and bytes seen on the wired bus.
module tb_i2c_master;

  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;
  logic        int_sig_o;

  logic        slave_pull    = 1'b0;
  bit          slave_present = 1'b1;
  logic [7:0]  read_value    = 8'h00;
  logic        last_ack      = 1'b0;
  int          bus_log[$];
  int          exp_log[$];
  int          int_count     = 0;
  int          n_compared    = 0;
  int          n_mismatched  = 0;

  assign sda_i = ~(sda_oe | slave_pull);

  i2c_master dut (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i),
    .int_sig_o (int_sig_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count interrupt pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (int_sig_o) int_count++;
    end
  end

  // Slave model: decodes START/STOP, receives bytes, ACKs when present and
  // returns read_value after an address byte with the read bit set.
  initial begin : slave_model
    logic       scl_now, sda_now, scl_prev, sda_prev;
    logic [7:0] rx_byte;
    int         bit_cnt;
    bit         first_byte, tx_mode, tx_next;
    scl_prev = 1'b1; sda_prev = 1'b1; rx_byte = 8'h00; bit_cnt = 0;
    first_byte = 1'b0; tx_mode = 1'b0; tx_next = 1'b0;
    forever begin
      @(negedge clk);
      scl_now = ~scl_oe;
      sda_now = sda_i;
      if (!rst) begin
        slave_pull = 1'b0; bit_cnt = 0; tx_mode = 1'b0; tx_next = 1'b0; first_byte = 1'b0;
      end else if (scl_now && scl_prev && sda_prev && !sda_now) begin
        bus_log.push_back(EV_START);
        bit_cnt = 0; first_byte = 1'b1; tx_mode = 1'b0; tx_next = 1'b0; slave_pull = 1'b0;
      end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
        bus_log.push_back(EV_STOP);
        bit_cnt = 0; tx_mode = 1'b0; tx_next = 1'b0; slave_pull = 1'b0;
      end else if (scl_now && !scl_prev) begin
        if (bit_cnt < 8) rx_byte = {rx_byte[6:0], sda_now};
        else             last_ack = sda_now;
        bit_cnt++;
      end else if (!scl_now && scl_prev) begin
        if (bit_cnt == 8) begin
          bus_log.push_back(int'(rx_byte));
          if (tx_mode) begin
            slave_pull = 1'b0;
          end else begin
            slave_pull = slave_present;
            tx_next    = first_byte && rx_byte[0];
          end
          first_byte = 1'b0;
        end else if (bit_cnt >= 9) begin
          bit_cnt    = 0;
          slave_pull = 1'b0;
          if (tx_next) begin
            tx_mode    = 1'b1;
            tx_next    = 1'b0;
            slave_pull = ~read_value[7];
          end else begin
            tx_mode = 1'b0;
          end
        end else if (tx_mode && bit_cnt >= 1) begin
          slave_pull = ~read_value[7 - bit_cnt];
        end
      end
      scl_prev = scl_now;
      sda_prev = sda_now;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One register write cycle; returns at the falling edge after the write edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i = 1'b1; addr_i = {24'h0, a}; data_i = d;
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr_i = {24'h0, a};
    #1;
    checkOutput(tag, data_o, exp);
  endtask

  // Counts cycles with BUSY set, then checks BUSY is clear and int is high
  // in the first cycle after.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    addr_i = 32'h0;
    #1;
    while (data_o[2] && cycles < 5000) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_busy_clear"}, {31'd0, data_o[2]}, 32'd0);
    checkOutput({tag, "_int_pulse"}, {31'd0, int_sig_o}, 32'd1);
  endtask

  task automatic check_log(input string tag);
    int n;
    checkOutput({tag, "_len"}, bus_log.size(), exp_log.size());
    n = (bus_log.size() < exp_log.size()) ? bus_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), bus_log[i], exp_log[i]);
  endtask

  initial begin
    int cycles;
    int int_before;
    int k;
    rst = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    $display("[TB] reset state");
    #1;
    checkOutput("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("rst_int", {31'd0, int_sig_o}, 32'd0);
    check_reg("rst_ctrl", 8'h00, 32'h0);
    check_reg("rst_div", 8'h04, 32'd125);
    check_reg("rst_addr", 8'h08, 32'h0);
    check_reg("rst_data", 8'h0C, 32'h0);
    check_reg("unmapped_10", 8'h10, 32'h0);

    $display("[TB] write transaction");
    applyStimulus(8'h04, 32'd4);
    applyStimulus(8'h08, 32'h0000_1050);
    applyStimulus(8'h0C, 32'hFFFF_FFA5);
    check_reg("addr_rb", 8'h08, 32'h0000_1050);
    check_reg("data_rb", 8'h0C, 32'h0000_00A5);
    slave_present = 1'b1;
    bus_log.delete();
    int_before = int_count;
    applyStimulus(8'h00, 32'h1);
    wait_done("wr", cycles);
    checkOutput("wr_busy_cycles", cycles, 464);
    @(negedge clk); #1;
    checkOutput("wr_int_low_after", {31'd0, int_sig_o}, 32'd0);
    checkOutput("wr_int_count", int_count - int_before, 1);
    check_reg("wr_ctrl_after", 8'h00, 32'h0);
    checkOutput("wr_last_ack", {31'd0, last_ack}, 32'd0);
    exp_log = '{EV_START, 'hA0, 'h10, 'hA5, EV_STOP};
    check_log("wr_bus");

    $display("[TB] busy lockout");
    applyStimulus(8'h0C, 32'h5A);
    bus_log.delete();
    applyStimulus(8'h00, 32'h1);
    check_reg("lock_ctrl_busy", 8'h00, 32'h4);
    repeat (20) @(negedge clk);
    applyStimulus(8'h0C, 32'hFF);
    applyStimulus(8'h00, 32'h3);
    applyStimulus(8'h04, 32'd7);
    applyStimulus(8'h08, 32'h0000_7777);
    wait_done("lock", cycles);
    check_reg("lock_data", 8'h0C, 32'h5A);
    check_reg("lock_div", 8'h04, 32'd4);
    check_reg("lock_addr", 8'h08, 32'h0000_1050);
    check_reg("lock_ctrl_after", 8'h00, 32'h0);
    exp_log = '{EV_START, 'hA0, 'h10, 'h5A, EV_STOP};
    check_log("lock_bus");

    $display("[TB] read transaction");
    applyStimulus(8'h08, 32'h0000_2250);
    read_value = 8'h3C;
    bus_log.delete();
    applyStimulus(8'h00, 32'h3);
    wait_done("rd", cycles);
    checkOutput("rd_busy_cycles", cycles, 624);
    check_reg("rd_data", 8'h0C, 32'h3C);
    check_reg("rd_ctrl_after", 8'h00, 32'h2);
    checkOutput("rd_master_nack", {31'd0, last_ack}, 32'd1);
    exp_log = '{EV_START, 'hA0, 'h22, EV_START, 'hA1, 'h3C, EV_STOP};
    check_log("rd_bus");

    $display("[TB] NACK on write, DIV=2");
    slave_present = 1'b0;
    applyStimulus(8'h04, 32'd2);
    applyStimulus(8'h08, 32'h0000_1050);
    bus_log.delete();
    applyStimulus(8'h00, 32'h1);
    wait_done("nack", cycles);
    checkOutput("nack_busy_cycles", cycles, 88);
    checkOutput("nack_ack_high", {31'd0, last_ack}, 32'd1);
    check_reg("nack_ctrl", 8'h00, 32'h8);
    check_reg("nack_data", 8'h0C, 32'h3C);
    exp_log = '{EV_START, 'hA0, EV_STOP};
    check_log("nack_bus");

    $display("[TB] failed read, DIV=0");
    applyStimulus(8'h04, 32'd0);
    check_reg("div0_rb", 8'h04, 32'd0);
    bus_log.delete();
    applyStimulus(8'h00, 32'h3);
    wait_done("frd", cycles);
    checkOutput("frd_busy_cycles", cycles, 88);
    check_reg("frd_ctrl", 8'h00, 32'hA);
    check_reg("frd_data", 8'h0C, 32'h3C);
    exp_log = '{EV_START, 'hA0, EV_STOP};
    check_log("frd_bus");

    $display("[TB] next GO clears NACK");
    slave_present = 1'b1;
    applyStimulus(8'h08, 32'h0000_2250);
    bus_log.delete();
    applyStimulus(8'h00, 32'h1);
    check_reg("clr_ctrl_busy", 8'h00, 32'h4);
    wait_done("clr", cycles);
    check_reg("clr_ctrl_after", 8'h00, 32'h0);
    exp_log = '{EV_START, 'hA0, 'h22, 'h3C, EV_STOP};
    check_log("clr_bus");

    $display("[TB] asynchronous reset mid-read");
    applyStimulus(8'h04, 32'd4);
    read_value = 8'h99;
    applyStimulus(8'h00, 32'h3);
    repeat (100) @(negedge clk);
    k = 0;
    while (!(scl_oe && sda_oe) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_mid_pre_oe", {30'd0, scl_oe, sda_oe}, 32'h3);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_scl_oe", {31'd0, scl_oe}, 32'd0);
    checkOutput("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
    addr_i = 32'h0; #1;
    checkOutput("rst_mid_ctrl", data_o, 32'h0);
    addr_i = 32'h4; #1;
    checkOutput("rst_mid_div", data_o, 32'd125);
    addr_i = 32'hC; #1;
    checkOutput("rst_mid_data", data_o, 32'h0);
    addr_i = 32'h8; #1;
    checkOutput("rst_mid_addr", data_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("post_rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_reg("post_rst_ctrl", 8'h00, 32'h0);
    check_reg("unmapped_40", 8'h40, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
